// File: rtl/parking_meter_counter.sv
// Parking meter time-keeping stage.
// Holds the remaining parking time in seconds. Coin and preset buttons add to
// or load this time, and a prescaler removes one second per TICK_CYCLES clocks.
// The 16-bit result feeds the binary-to-BCD display stage.
module parking_meter_counter #(
   parameter int TICK_CYCLES = 100_000_000,
   parameter int MAX_TIME    = 9999,
   parameter int PRESET_A    = 10,
   parameter int PRESET_B    = 205
) (
   input  logic        SYS_CLK,
   input  logic        RESET,
   input  logic        BTN_ADD50,
   input  logic        BTN_ADD150,
   input  logic        BTN_ADD200,
   input  logic        BTN_ADD500,
   input  logic        BTN_PRESET_A,
   input  logic        BTN_PRESET_B,
   output logic [15:0] Out_Bin16,
   output logic        Out_Tick,
   output logic        Out_Zero
);

   localparam int                 PRESC_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(TICK_CYCLES - 1);
   localparam logic [16:0]        MAX_TIME_17 = 17'(MAX_TIME);

   typedef enum logic {
      EXPIRED = 1'b0,
      RUNNING = 1'b1
   } state_t;

   // Button bit order: {PRESET_B, PRESET_A, ADD500, ADD200, ADD150, ADD50}
   logic [5:0] btn_raw;
   logic [5:0] btn_sync1;
   logic [5:0] btn_sync2;
   logic [5:0] btn_prev;
   logic [5:0] btn_event;

   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] presc_next;
   logic               tick_next;
   logic               wrap;
   logic               decrement;
   logic               preset_load;
   logic               presc_clear;

   state_t      state;
   state_t      state_next;
   logic [9:0]  coin_sum;
   logic [16:0] sum17;
   logic [15:0] value_next;
   logic        zero_next;

   assign btn_raw   = {BTN_PRESET_B, BTN_PRESET_A, BTN_ADD500, BTN_ADD200, BTN_ADD150, BTN_ADD50};
   assign btn_event = btn_sync2 & ~btn_prev;

   // Two-flop synchronizer plus a history flop, so each press yields a single event.
   always_ff @(posedge SYS_CLK or negedge RESET) begin
      if (!RESET) begin
         btn_sync1 <= '0;
         btn_sync2 <= '0;
         btn_prev  <= '0;
      end else begin
         btn_sync1 <= btn_raw;
         btn_sync2 <= btn_sync1;
         btn_prev  <= btn_sync2;
      end
   end

   // One-second prescaler and its registered tick pulse.
   always_ff @(posedge SYS_CLK or negedge RESET) begin
      if (!RESET) begin
         presc    <= '0;
         Out_Tick <= 1'b0;
      end else begin
         presc    <= presc_next;
         Out_Tick <= tick_next;
      end
   end

   // State register, with the time value and its zero flag updated in the same edge.
   always_ff @(posedge SYS_CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= EXPIRED;
         Out_Bin16 <= '0;
         Out_Zero  <= 1'b1;
      end else begin
         state     <= state_next;
         Out_Bin16 <= value_next;
         Out_Zero  <= zero_next;
      end
   end

   // Next value: presets win over coins; coins and tick combine before clamping at MAX_TIME.
   always_comb begin
      wrap        = (presc == PRESC_LAST);
      decrement   = wrap && (Out_Bin16 != 16'd0);
      preset_load = 1'b0;
      coin_sum    = 10'd0;
      if (btn_event[0]) coin_sum = coin_sum + 10'd50;
      if (btn_event[1]) coin_sum = coin_sum + 10'd150;
      if (btn_event[2]) coin_sum = coin_sum + 10'd200;
      if (btn_event[3]) coin_sum = coin_sum + 10'd500;
      sum17 = {1'b0, Out_Bin16} + {7'd0, coin_sum} - {16'd0, decrement};

      if (btn_event[5]) begin
         value_next  = 16'(PRESET_B);
         preset_load = 1'b1;
      end else if (btn_event[4]) begin
         value_next  = 16'(PRESET_A);
         preset_load = 1'b1;
      end else if (sum17 > MAX_TIME_17) begin
         value_next  = MAX_TIME_17[15:0];
      end else begin
         value_next  = sum17[15:0];
      end
      zero_next = (value_next == 16'd0);

      state_next = state;
      case (state)
         EXPIRED: if (value_next != 16'd0) state_next = RUNNING;
         RUNNING: if (value_next == 16'd0) state_next = EXPIRED;
         default: state_next = EXPIRED;
      endcase

      presc_clear = preset_load || ((state == EXPIRED) && (state_next == RUNNING));
      if (presc_clear || wrap) begin
         presc_next = '0;
      end else begin
         presc_next = presc + PRESC_W'(1);
      end
      tick_next = wrap && !presc_clear;
   end

endmodule

// File: tb/tb_parking_meter_counter.sv
// Directed self-checking bench for parking_meter_counter with TICK_CYCLES = 10.
// Expected values are hand-computed and counted in edges after each button rises.
module tb_parking_meter_counter;

   localparam logic [5:0] ADD50    = 6'b000001;
   localparam logic [5:0] ADD150   = 6'b000010;
   localparam logic [5:0] ADD200   = 6'b000100;
   localparam logic [5:0] ADD500   = 6'b001000;
   localparam logic [5:0] PRESET_A = 6'b010000;
   localparam logic [5:0] PRESET_B = 6'b100000;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [5:0]  btn_drive = '0;
   logic [15:0] out_bin16;
   logic        out_tick;
   logic        out_zero;

   int total_count = 0;
   int bad_count   = 0;

   parking_meter_counter #(
      .TICK_CYCLES(10),
      .MAX_TIME(9999),
      .PRESET_A(10),
      .PRESET_B(205)
   ) dut (
      .SYS_CLK(sys_clk),
      .RESET(reset_n),
      .BTN_ADD50(btn_drive[0]),
      .BTN_ADD150(btn_drive[1]),
      .BTN_ADD200(btn_drive[2]),
      .BTN_ADD500(btn_drive[3]),
      .BTN_PRESET_A(btn_drive[4]),
      .BTN_PRESET_B(btn_drive[5]),
      .Out_Bin16(out_bin16),
      .Out_Tick(out_tick),
      .Out_Zero(out_zero)
   );

   // Free-running 100 MHz system clock.
   always #5 sys_clk = ~sys_clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // Raise the given buttons for one cycle, then release them for one cycle.
   task automatic applyStimulus(input logic [5:0] mask);
      btn_drive = mask;
      step(1);
      btn_drive = '0;
      step(1);
   endtask

   // Compare one observed value with its expected value and count the outcome.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_count++;
      if (observed !== expected) begin
         bad_count++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Assert reset asynchronously, hold it two edges, release just after an edge.
   task automatic doReset();
      reset_n = 1'b0;
      step(2);
      reset_n = 1'b1;
   endtask

   initial begin
      int changed;
      int saw_tick;

      // Reset values
      step(2);
      checkOutput("rst_bin", out_bin16, 0);
      checkOutput("rst_tick", out_tick, 0);
      checkOutput("rst_zero", out_zero, 1);
      reset_n = 1'b1;

      // 1) Idle for 50 cycles
      changed = 0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (out_bin16 !== 16'd0 || out_zero !== 1'b1) changed = 1;
      end
      checkOutput("t1_stable", changed, 0);
      checkOutput("t1_bin", out_bin16, 0);

      // 2) One +50 coin, countdown to zero
      btn_drive = ADD50;
      step(1);
      btn_drive = '0;
      step(1);
      checkOutput("t2_latency", out_bin16, 0);
      step(1);
      checkOutput("t2_add50", out_bin16, 50);
      checkOutput("t2_zero_lo", out_zero, 0);
      step(9);
      checkOutput("t2_pre_tick", out_bin16, 50);
      step(1);
      checkOutput("t2_first_dec", out_bin16, 49);
      checkOutput("t2_tick_hi", out_tick, 1);
      step(1);
      checkOutput("t2_tick_lo", out_tick, 0);
      step(488);
      checkOutput("t2_last_sec", out_bin16, 1);
      step(1);
      checkOutput("t2_expired", out_bin16, 0);
      checkOutput("t2_zero_hi", out_zero, 1);
      step(30);
      checkOutput("t2_stays", out_bin16, 0);

      // 3) Saturate near the top, then hold +500 across several ticks
      applyStimulus(PRESET_B);
      repeat (11) applyStimulus(ADD50 | ADD150 | ADD200 | ADD500);
      step(1);
      checkOutput("t3_saturate", out_bin16, 9999);
      step(88);
      checkOutput("t3_at_9990", out_bin16, 9990);
      step(3);
      btn_drive = ADD500;
      step(3);
      checkOutput("t3_clamp", out_bin16, 9999);
      step(21);
      checkOutput("t3_held_once", out_bin16, 9997);
      btn_drive = '0;
      step(3);
      checkOutput("t3_release", out_bin16, 9996);

      // 4) Preset A and +150 in the same cycle
      btn_drive = PRESET_A | ADD150;
      step(1);
      btn_drive = '0;
      step(2);
      checkOutput("t4_preset_wins", out_bin16, 10);
      step(7);
      checkOutput("t4_restart", out_bin16, 10);
      step(3);
      checkOutput("t4_first_dec", out_bin16, 9);
      checkOutput("t4_tick", out_tick, 1);

      // 5) Coin landing on a tick, then two coins in one cycle
      doReset();
      applyStimulus(ADD50);
      applyStimulus(ADD50);
      checkOutput("t5_fifty", out_bin16, 50);
      step(6);
      btn_drive = ADD50;
      step(1);
      btn_drive = '0;
      step(1);
      checkOutput("t5_hundred", out_bin16, 100);
      step(1);
      checkOutput("t5_coin_tick", out_bin16, 149);
      checkOutput("t5_tick", out_tick, 1);

      doReset();
      btn_drive = ADD200 | ADD500;
      step(1);
      btn_drive = '0;
      step(1);
      checkOutput("t5_sum_latency", out_bin16, 0);
      step(1);
      checkOutput("t5_sum", out_bin16, 700);

      // 6) Asynchronous reset in the middle of a count
      applyStimulus(PRESET_B);
      step(1);
      checkOutput("t6_preset_b", out_bin16, 205);
      step(4);
      checkOutput("t6_holding", out_bin16, 205);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("t6_async_bin", out_bin16, 0);
      checkOutput("t6_async_zero", out_zero, 1);
      step(2);
      reset_n = 1'b1;
      changed  = 0;
      saw_tick = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (out_tick !== 1'b0) saw_tick = 1;
         if (out_bin16 !== 16'd0) changed = 1;
      end
      checkOutput("t6_no_tick", saw_tick, 0);
      checkOutput("t6_no_event", changed, 0);
      checkOutput("t6_zero", out_zero, 1);

      $display("test done: total=%0d bad=%0d", total_count, bad_count);
      $finish;
   end

endmodule
